// File: rtl/result_fifo_m_pkg.sv
// Shared types and constants for the result FIFO slice.
//   RESULT_DATA_W      default result width (matches dout_if data width)
//   RESULT_FIFO_DEPTH  default FIFO depth, shared with the top level
//   data_t             result word type
package result_fifo_m_pkg;
  localparam int RESULT_DATA_W     = 32;
  localparam int RESULT_FIFO_DEPTH = 8;
  typedef logic [RESULT_DATA_W-1:0] data_t;
endpackage

// File: rtl/result_fifo_m_if.sv
// dout_if: one-cycle result strobe from the adder (no back-pressure).
//   valid  strobe, one cycle per result
//   data   result word
// Modports: m (producer), s (consumer).
interface dout_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic [DATA_W-1:0] data;

  modport m (output valid, output data);
  modport s (input  valid, input  data);
endinterface

// File: rtl/result_fifo_m_ram.sv
// result_fifo_ram_m: simple dual-port RAM, one write port, one read port with
// registered read data (read-before-write on an address collision).
//   clk    clock
//   we     write enable, waddr/wdata write address/data
//   raddr  read address, rdata registered read data (next cycle)
module result_fifo_ram_m #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/result_fifo_m.sv
// result_fifo_m: captures every adder result strobe into a FIFO and drains it
// over a valid/ready port with a first-word-fall-through output register.
// Results arriving while full (and not being read) are dropped and counted.
//   clk, rst       clock, asynchronous active-low reset
//   res            result strobe (dout_if.s)
//   m_valid/m_ready/m_data  output handshake, head entry
//   level          occupancy incl. output register, 0..DEPTH
//   ovf            sticky drop flag, drop_cnt saturating drop count
//   ovf_clr        synchronous clear of ovf/drop_cnt (wins over a drop)
module result_fifo_m
  import result_fifo_m_pkg::*;
#(
  parameter int DATA_W = RESULT_DATA_W,
  parameter int DEPTH  = RESULT_FIFO_DEPTH,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dout_if.s                        res,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // RAM holds only the entries behind the output register, so it never
  // needs more than DEPTH-1 slots and the pointers wrap naturally.
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DATA_W-1:0] ram_q, byp_data, head_data;
  logic              byp_hit;
  logic              rd_en, wr_en, drop, load_out, st_has, st_pop, ram_we;

  assign rd_en    = m_valid & m_ready;
  assign wr_en    = res.valid & ((level < LW'(DEPTH)) | rd_en);
  assign drop     = res.valid & (level == LW'(DEPTH)) & ~rd_en;
  assign st_has   = level > {{(LW-1){1'b0}}, m_valid};
  assign load_out = ~m_valid | rd_en;
  assign st_pop   = load_out & st_has;
  // A write goes straight to the output register only when it is free and
  // storage is empty; otherwise it lands in the RAM.
  assign ram_we   = wr_en & ~(load_out & ~st_has);
  assign rd_ptr_nxt = rd_ptr + {{(AW-1){1'b0}}, st_pop};

  // The RAM is always read at the pointer's next value so the storage head is
  // ready in ram_q. An entry written last cycle to that address is not yet
  // visible there, so it is forwarded from byp_data instead.
  assign head_data = byp_hit ? byp_data : ram_q;

  result_fifo_ram_m #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (res.data),
    .raddr (rd_ptr_nxt),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nxt;
      byp_hit  <= ram_we & (wr_ptr == rd_ptr_nxt);
      byp_data <= res.data;

      if (load_out) begin
        if (st_has) begin
          m_valid <= 1'b1;
          m_data  <= head_data;
        end else if (wr_en) begin
          m_valid <= 1'b1;
          m_data  <= res.data;
        end else begin
          m_valid <= 1'b0;
        end
      end

      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (ovf_clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_result_fifo_m.sv
module tb_result_fifo_m;
  import result_fifo_m_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             m_valid, ovf;
  logic             m_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  data_t            m_data;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drop_cnt;

  dout_if #(.DATA_W(RESULT_DATA_W)) res ();

  result_fifo_m #(.DATA_W(RESULT_DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .res      (res),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0, n_err = 0, n_out = 0;
  data_t sb [$];
  data_t last_q = '0;
  logic  ovf_q  = 1'b0;
  int    cnt_q  = 0;
  logic  mv_m, rd_m, wr_m, dr_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard / reference model, sampled mid-cycle while inputs are stable.
  // sb holds every accepted word including the one being presented.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      last_q = '0;
      ovf_q  = 1'b0;
      cnt_q  = 0;
      chk("rst_m_valid",  64'(m_valid),  0);
      chk("rst_m_data",   64'(m_data),   0);
      chk("rst_level",    64'(level),    0);
      chk("rst_ovf",      64'(ovf),      0);
      chk("rst_drop_cnt", 64'(drop_cnt), 0);
    end else begin
      mv_m = (sb.size() != 0);
      if (mv_m) last_q = sb[0];
      chk("m_valid",  64'(m_valid),  64'(mv_m));
      chk("m_data",   64'(m_data),   64'(last_q));
      chk("level",    64'(level),    64'(sb.size()));
      chk("ovf",      64'(ovf),      64'(ovf_q));
      chk("drop_cnt", 64'(drop_cnt), 64'(cnt_q));
      rd_m = mv_m & m_ready;
      wr_m = res.valid & ((sb.size() < DEPTH) | rd_m);
      dr_m = res.valid & (sb.size() == DEPTH) & ~rd_m;
      if (rd_m) begin
        void'(sb.pop_front());
        n_out++;
      end
      if (wr_m) sb.push_back(res.data);
      if (ovf_clr) begin
        ovf_q = 1'b0;
        cnt_q = 0;
      end else if (dr_m) begin
        ovf_q = 1'b1;
        if (cnt_q < CNT_MAX) cnt_q++;
      end
    end
  end

  task automatic cyc(input logic v, input data_t d, input logic rdy, input logic clr);
    res.valid = v;
    res.data  = d;
    m_ready   = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res.valid = 1'b0;
    res.data  = '0;
    @(posedge clk);
    #1;

    // reset held while strobes arrive: nothing captured
    repeat (3) cyc(1'b1, data_t'($urandom), 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t1_level",   64'(level),   0);
    chk("t1_m_valid", 64'(m_valid), 0);

    // single result, one-cycle latency
    cyc(1'b1, 32'h0000_0005, 1'b1, 1'b0);
    chk("t2_m_valid", 64'(m_valid), 1);
    chk("t2_m_data",  64'(m_data),  5);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_empty",   64'(m_valid), 0);
    chk("t2_level",   64'(level),   0);

    // fill and overflow
    for (int i = 1; i <= 10; i++) cyc(1'b1, data_t'(i), 1'b0, 1'b0);
    chk("t3_level", 64'(level),    8);
    chk("t3_ovf",   64'(ovf),      1);
    chk("t3_drops", 64'(drop_cnt), 2);

    // full with simultaneous read: write accepted
    cyc(1'b1, 32'd11, 1'b1, 1'b0);
    chk("t4_level", 64'(level),    8);
    chk("t4_drops", 64'(drop_cnt), 2);
    repeat (12) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t4_n_out", 64'(n_out), 10);
    chk("t4_drained", 64'(level), 0);

    // streaming with pointer wrap
    for (int i = 0; i < 100; i++) cyc(1'b1, data_t'(32'hA000_0000 + i), 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_n_out", 64'(n_out),    110);
    chk("t5_drops", 64'(drop_cnt), 2);
    chk("t5_level", 64'(level),    0);

    // random strobes with toggling ready
    repeat (60) cyc(1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5r_level", 64'(level), 0);

    // clear, saturation, clear racing a drop
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t6_clr_ovf", 64'(ovf),      0);
    chk("t6_clr_cnt", 64'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, data_t'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, data_t'(200 + i), 1'b0, 1'b0);
    chk("t6_sat_cnt", 64'(drop_cnt), 3);
    chk("t6_sat_ovf", 64'(ovf),      1);
    cyc(1'b1, 32'd300, 1'b0, 1'b1);
    chk("t6_race_ovf", 64'(ovf),      0);
    chk("t6_race_cnt", 64'(drop_cnt), 0);
    chk("t6_race_lvl", 64'(level),    8);

    // asynchronous reset mid-burst
    cyc(1'b1, 32'd400, 1'b1, 1'b0);
    cyc(1'b1, 32'd401, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_ar_m_valid", 64'(m_valid),  0);
    chk("t6_ar_m_data",  64'(m_data),   0);
    chk("t6_ar_level",   64'(level),    0);
    chk("t6_ar_ovf",     64'(ovf),      0);
    chk("t6_ar_cnt",     64'(drop_cnt), 0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    chk("t6_post_m_valid", 64'(m_valid), 1);
    chk("t6_post_m_data",  64'(m_data),  32'h55);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
